// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared write-back select encodings and register index constants
package cpu_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'b00,
        WB_SEL_MEM = 2'b01,
        WB_SEL_PC  = 2'b10,
        WB_SEL_RSV = 2'b11
    } wb_sel_e;

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 29;
    localparam int unsigned REG_RA   = 31;

    localparam logic [31:0] SP_RESET = 32'h0000_0800;

endpackage

// File: rtl/gpr_array.sv
// rtl/gpr_array.sv - GPR storage: one write port, two asynchronous read ports, no bypass
module gpr_array #(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 5,
    parameter int          SP_IDX  = 29,
    parameter logic [31:0] SP_INIT = 32'h0000_0800
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (i == SP_IDX) ? DATA_W'(SP_INIT) : '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = regs[raddr_a];
    assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back select, commit gating, bypassed read ports and commit counter
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 5,
    parameter int          SP_IDX  = REG_SP,
    parameter logic [31:0] SP_INIT = SP_RESET
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] mem_out,
    input  logic [DATA_W-1:0] pc_next,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [1:0]        MemtoReg,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_commit,
    output logic [31:0]       commit_cnt
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] arr_rs;
    logic [DATA_W-1:0] arr_rt;
    logic [31:0]       cnt_q;

    always_comb begin
        wb_data = alu_out;
        case (wb_sel_e'(MemtoReg))
            WB_SEL_MEM: wb_data = mem_out;
            WB_SEL_PC:  wb_data = pc_next;
            default:    wb_data = alu_out;
        endcase
    end

    // Reset level gates the commit so an edge during reset cannot write, and the bypass goes dark with it.
    assign wb_commit = RegWrite && (write_addr != ZERO_IDX) && reset;

    gpr_array #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .SP_IDX  (SP_IDX),
        .SP_INIT (SP_INIT)
    ) u_gpr (
        .clk     (clk),
        .reset   (reset),
        .we      (wb_commit),
        .waddr   (write_addr),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (arr_rs),
        .rdata_b (arr_rt)
    );

    always_comb begin
        rs_data = arr_rs;
        if (rs_addr == ZERO_IDX) begin
            rs_data = '0;
        end else if (wb_commit && (rs_addr == write_addr)) begin
            rs_data = wb_data;
        end
    end

    always_comb begin
        rt_data = arr_rt;
        if (rt_addr == ZERO_IDX) begin
            rt_data = '0;
        end else if (wb_commit && (rt_addr == write_addr)) begin
            rt_data = wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (wb_commit) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - vector table, corner sequences and randomized reference-model checks for wb_regfile
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [31:0] alu_out;
    logic [31:0] mem_out;
    logic [31:0] pc_next;
    logic [4:0]  write_addr;
    logic [1:0]  MemtoReg;
    logic        RegWrite;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic        wb_commit;
    logic [31:0] commit_cnt;

    wb_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .alu_out    (alu_out),
        .mem_out    (mem_out),
        .pc_next    (pc_next),
        .write_addr (write_addr),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .wb_data    (wb_data),
        .wb_commit  (wb_commit),
        .commit_cnt (commit_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rw;
        logic [1:0]  sel;
        logic [4:0]  wa;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] e_wb;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic        e_commit;
    } vec_t;

    localparam logic [31:0] VA = 32'hAAAA_0001;
    localparam logic [31:0] VB = 32'hBBBB_0002;
    localparam logic [31:0] VC = 32'hCCCC_0003;
    localparam logic [31:0] VD = 32'hDEAD_BEEF;

    vec_t        tbl [8];
    logic [31:0] mreg [32];
    logic [31:0] mcnt;
    int          n_cmp;
    int          n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_wb();
        case (MemtoReg)
            2'b01:   return mem_out;
            2'b10:   return pc_next;
            default: return alu_out;
        endcase
    endfunction

    function automatic logic m_commit();
        return RegWrite && (write_addr != 5'd0) && reset;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_commit() && a == write_addr) return m_wb();
        return mreg[a];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
        mreg[29] = 32'h0000_0800;
        mcnt = 32'd0;
    endtask

    // Called just after a negedge with inputs settled; returns at the next negedge.
    task automatic do_edge();
        logic        c;
        logic [31:0] w;
        logic [4:0]  a;
        c = m_commit();
        w = m_wb();
        a = write_addr;
        @(posedge clk);
        if (c) begin
            mreg[a] = w;
            mcnt    = mcnt + 32'd1;
        end
        @(negedge clk);
    endtask

    task automatic check_ports(input string tag);
        #1;
        check({tag, " wb_data"},    wb_data,           m_wb());
        check({tag, " wb_commit"},  {31'd0, wb_commit}, {31'd0, m_commit()});
        check({tag, " rs_data"},    rs_data,           m_read(rs_addr));
        check({tag, " rt_data"},    rt_data,           m_read(rt_addr));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        tbl[0] = '{1'b1, 2'b00, 5'd5,  VA, VB, VC, 5'd5,  5'd0,  VA, VA, 32'd0, 1'b1};
        tbl[1] = '{1'b1, 2'b01, 5'd5,  VA, VB, VC, 5'd5,  5'd0,  VB, VB, 32'd0, 1'b1};
        tbl[2] = '{1'b1, 2'b10, 5'd5,  VA, VB, VC, 5'd5,  5'd0,  VC, VC, 32'd0, 1'b1};
        tbl[3] = '{1'b1, 2'b11, 5'd5,  VA, VB, VC, 5'd5,  5'd0,  VA, VA, 32'd0, 1'b1};
        tbl[4] = '{1'b1, 2'b01, 5'd7,  VA, VD, VC, 5'd7,  5'd7,  VD, VD, VD,    1'b1};
        tbl[5] = '{1'b1, 2'b00, 5'd0,  32'h1234, VB, VC, 5'd0, 5'd5, 32'h1234, 32'd0, VA, 1'b0};
        tbl[6] = '{1'b0, 2'b10, 5'd5,  VA, VB, VC, 5'd5,  5'd7,  VC, VA, VD,    1'b0};
        tbl[7] = '{1'b1, 2'b00, 5'd29, 32'h100, VB, VC, 5'd29, 5'd31, 32'h100, 32'h100, 32'd0, 1'b1};

        reset = 1'b0;
        alu_out = 32'd0; mem_out = 32'd0; pc_next = 32'd0;
        write_addr = 5'd3; MemtoReg = 2'b00; RegWrite = 1'b1;
        rs_addr = 5'd0; rt_addr = 5'd0;
        m_reset();
        alu_out = 32'h5555_5555;
        repeat (2) @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            check("reset rs_data", rs_data, (i == 29) ? 32'h0000_0800 : 32'd0);
            check("reset rt_data", rt_data, (31 - i == 29) ? 32'h0000_0800 : 32'd0);
        end
        check("reset commit_cnt", commit_cnt, 32'd0);
        check("reset wb_commit", {31'd0, wb_commit}, 32'd0);
        RegWrite = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            RegWrite = tbl[i].rw; MemtoReg = tbl[i].sel; write_addr = tbl[i].wa;
            alu_out = tbl[i].alu; mem_out = tbl[i].mem; pc_next = tbl[i].pc;
            rs_addr = tbl[i].rs; rt_addr = tbl[i].rt;
            #1;
            check($sformatf("vec%0d wb_data", i), wb_data, tbl[i].e_wb);
            check($sformatf("vec%0d wb_commit", i), {31'd0, wb_commit}, {31'd0, tbl[i].e_commit});
            check($sformatf("vec%0d rs_data", i), rs_data, tbl[i].e_rs);
            check($sformatf("vec%0d rt_data", i), rt_data, tbl[i].e_rt);
            do_edge();
            RegWrite = 1'b0;
            #1;
            check($sformatf("vec%0d rs after edge", i), rs_data, m_read(rs_addr));
            check($sformatf("vec%0d rt after edge", i), rt_data, m_read(rt_addr));
            check($sformatf("vec%0d commit_cnt", i), commit_cnt, mcnt);
            if (i == 3) check("mux commit_cnt", commit_cnt, 32'd4);
        end

        // Async reset landing between edges while a write to GPR9 is pending.
        RegWrite = 1'b1; MemtoReg = 2'b00; write_addr = 5'd9; alu_out = 32'h9999_0001;
        rs_addr = 5'd9; rt_addr = 5'd29;
        do_edge();
        alu_out = 32'h9999_0002;
        #2 reset = 1'b0;
        #1;
        m_reset();
        check("async rs9", rs_data, 32'd0);
        check("async rt29", rt_data, 32'h0000_0800);
        check("async commit_cnt", commit_cnt, 32'd0);
        check("async wb_commit", {31'd0, wb_commit}, 32'd0);
        do_edge();
        check("reset-edge rs9", rs_data, 32'd0);
        check("reset-edge commit_cnt", commit_cnt, 32'd0);
        reset = 1'b1;
        check_ports("post-reset write");
        do_edge();
        RegWrite = 1'b0;
        #1;
        check("post-reset rs9", rs_data, 32'h9999_0002);
        check("post-reset commit_cnt", commit_cnt, 32'd1);

        // Counter wrap: preload the counter, then a single commit.
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        #1;
        check("wrap preload", commit_cnt, 32'hFFFF_FFFF);
        mcnt = 32'hFFFF_FFFF;
        RegWrite = 1'b1; write_addr = 5'd12; alu_out = 32'h0C0C_0C0C; MemtoReg = 2'b11;
        do_edge();
        RegWrite = 1'b0;
        #1;
        check("wrap commit_cnt", commit_cnt, 32'd0);
        check("wrap model cnt", commit_cnt, mcnt);

        for (int k = 0; k < 300; k++) begin
            RegWrite   = ($urandom_range(0, 3) != 0) && (k < 240);
            MemtoReg   = 2'($urandom_range(0, 3));
            write_addr = 5'($urandom_range(0, 31));
            alu_out    = $urandom;
            mem_out    = $urandom;
            pc_next    = $urandom;
            rs_addr    = ($urandom_range(0, 2) == 0) ? write_addr : 5'($urandom_range(0, 31));
            rt_addr    = ($urandom_range(0, 2) == 0) ? write_addr : 5'($urandom_range(0, 31));
            check_ports($sformatf("rand%0d", k));
            do_edge();
            #1;
            check($sformatf("rand%0d commit_cnt", k), commit_cnt, mcnt);
        end

        RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(i);
            #1;
            check($sformatf("final gpr%0d rs", i), rs_data, mreg[i]);
            check($sformatf("final gpr%0d rt", i), rt_data, (i == 0) ? 32'd0 : mreg[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
